vector_config_unit: RTL



---
 rtl/vector_config_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vector_config_unit.sv
// Decodes vsetvl/vsetvli and vector CSR reads from the APU offload port into a
// one-cycle CSR write, then returns vl or the CSR value two cycles after grant.
module vector_config_unit #(
  parameter int unsigned VLENB = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        apu_req,
  output logic        apu_gnt,
  input  logic [31:0] apu_op,
  input  logic [31:0] apu_operand_a,
  input  logic [31:0] apu_operand_b,
  output logic        apu_rvalid,
  output logic [31:0] apu_result,
  output logic        apu_illegal,
  output logic        csr_write,
  output logic [31:0] csr_avl,
  output logic [4:0]  csr_vtype,
  output logic        csr_preserve_vl,
  output logic        csr_set_vl_max,
  input  logic [4:0]  vl_in,
  input  logic [1:0]  vsew_in,
  input  logic [1:0]  vlmul_in
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q;
  logic [31:0] opa_q;
  logic [4:0]  opb_q;

  // Only the low vtype bits of rs2 matter for vsetvl.
  logic unused_opb;
  assign unused_opb = ^apu_operand_b[31:5];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [11:0] csr_addr;
  logic [4:0]  vtype;
  logic        is_vset;
  logic        vset_legal;
  logic        is_csr_rd;

  assign opcode   = op_q[6:0];
  assign funct3   = op_q[14:12];
  assign rs1      = op_q[19:15];
  assign rd       = op_q[11:7];
  assign csr_addr = op_q[31:20];

  assign is_vset    = (opcode == 7'b1010111) && (funct3 == 3'b111);
  assign vtype      = op_q[31] ? opb_q : op_q[24:20];
  assign vset_legal = is_vset && !vtype[4] && (vtype[4:2] <= 3'd2);
  assign is_csr_rd  = (opcode == 7'b1110011) && (funct3 == 3'b010) && (rs1 == 5'd0) &&
                      ((csr_addr == 12'hC20) || (csr_addr == 12'hC21) || (csr_addr == 12'hC22));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      if (apu_gnt) begin
        op_q  <= apu_op;
        opa_q <= apu_operand_a;
        opb_q <= apu_operand_b[4:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    apu_gnt         = 1'b0;
    apu_rvalid      = 1'b0;
    apu_result      = '0;
    apu_illegal     = 1'b0;
    csr_write       = 1'b0;
    csr_avl         = '0;
    csr_vtype       = '0;
    csr_preserve_vl = 1'b0;
    csr_set_vl_max  = 1'b0;
    case (state_q)
      IDLE: begin
        if (apu_req && n_reset) begin
          apu_gnt = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        if (vset_legal) begin
          csr_write = 1'b1;
          csr_vtype = vtype;
          if (rs1 != 5'd0) begin
            csr_avl = opa_q;
          end else if (rd != 5'd0) begin
            csr_set_vl_max = 1'b1;
          end else begin
            csr_preserve_vl = 1'b1;
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        apu_rvalid = 1'b1;
        // The CSR block updated vl on the edge that ended EXEC, so vl_in is already current.
        if (vset_legal) begin
          apu_result = {27'b0, vl_in};
        end else if (is_csr_rd) begin
          case (csr_addr)
            12'hC20: apu_result = {27'b0, vl_in};
            12'hC21: apu_result = {28'b0, vsew_in, vlmul_in};
            default: apu_result = 32'(VLENB);
          endcase
        end else begin
          apu_illegal = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
